inst_cache: RTL and testbench

Direct-mapped instruction cache that replaces the single-cycle instruction ROM in front of the fetch stage. It sits between the PC register (upstream) and the decode/register-file stage (downstream), and serves instruction words over a valid/ready handshake. On a miss it refills a full line from a burst-read memory port and then returns the requested word.

---
 rtl/inst_cache_pkg.sv | 21 ++
 rtl/inst_cache_if.sv | 32 +++
 rtl/inst_cache_array.sv | 60 ++++++
 rtl/inst_cache.sv | 160 ++++++++++++++++
 tb/tb_inst_cache.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared types and defaults for the instruction cache.
//   INST_CACHE_LINES / INST_CACHE_WORDS : default geometry (lines, words per line)
//   DType / Instr                       : 32-bit address/data and instruction words
//   ICacheState                         : controller FSM states
package inst_cache_pkg;

  localparam int unsigned INST_CACHE_LINES = 16;
  localparam int unsigned INST_CACHE_WORDS = 4;

  typedef logic [31:0] DType;
  typedef logic [31:0] Instr;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESPOND
  } ICacheState;

endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: fetch-side and memory-side handshake bundle of the instruction cache.
//   cpu_*  : fetch request/response (valid/ready request, rvalid/rdata response)
//   flush  : single-cycle invalidate-all request
//   mem_*  : line-read request channel and refill beat channel
// Modports: slave = cache side, master = fetch unit / memory side.
interface inst_cache_if;
  import inst_cache_pkg::*;

  logic cpu_req;
  DType cpu_addr;
  logic cpu_ready;
  logic cpu_rvalid;
  Instr cpu_rdata;
  logic flush;

  logic mem_req_valid;
  logic mem_req_ready;
  DType mem_req_addr;
  logic mem_resp_valid;
  DType mem_resp_data;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_ready, cpu_rvalid, cpu_rdata, mem_req_valid, mem_req_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/inst_cache_array.sv
// inst_cache_array: valid/tag/data storage of the direct-mapped instruction cache.
//   clk, reset : clock, asynchronous active-high reset (clears valid bits)
//   clear      : synchronous invalidate of every line
//   idx        : line index shared by the asynchronous read and the writes
//   rd_off     : word offset for the asynchronous data read
//   rd_valid, rd_tag, rd_word : read results for idx / rd_off
//   word_we, wr_off, wr_word  : single-word write into line idx
//   tag_we, wr_tag            : tag write for line idx, also marks it valid
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = INST_CACHE_LINES,
  parameter int unsigned WORDS = INST_CACHE_WORDS,
  parameter int unsigned TAGW  = 30 - $clog2(INST_CACHE_LINES) - $clog2(INST_CACHE_WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [$clog2(LINES)-1:0] idx,
  input  logic [$clog2(WORDS)-1:0] rd_off,
  output logic                     rd_valid,
  output logic [TAGW-1:0]          rd_tag,
  output Instr                     rd_word,
  input  logic                     word_we,
  input  logic [$clog2(WORDS)-1:0] wr_off,
  input  Instr                     wr_word,
  input  logic                     tag_we,
  input  logic [TAGW-1:0]          wr_tag
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  Instr             data_q [LINES][WORDS];

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_word  = data_q[idx][rd_off];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[idx] <= wr_tag;
    end
    if (word_we) begin
      data_q[idx][wr_off] <= wr_word;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache between the PC register and decode.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : inst_cache_if.slave carrying the fetch request/response,
//                the flush pulse, and the line-read / refill-beat memory channels
// Hits return one cycle after acceptance and can stream one word per cycle;
// misses fetch a whole line in ascending word order and then return the word.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = INST_CACHE_LINES,
  parameter int unsigned WORDS = INST_CACHE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  inst_cache_if.slave bus
);

  localparam int unsigned OW = $clog2(WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 30 - OW - IW;

  ICacheState    state, state_nxt;
  logic [29:0]   addr_q;   // word address of the request being served
  logic [OW-1:0] beat_q;
  logic          flush_pend;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;

  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  Instr          rd_word;
  logic          hit;

  logic          latch, beat_clr, word_we, tag_we, flush_clear;
  logic          ready_c, rvalid_c, mreq_c;
  Instr          rdata_c;
  DType          maddr_c;

  // Byte-select bits of the fetch address play no part in a word fetch.
  logic          addr_lsb_unused;
  assign addr_lsb_unused = ^bus.cpu_addr[1:0];

  assign off = addr_q[OW-1:0];
  assign idx = addr_q[OW +: IW];
  assign tag = addr_q[29 -: TW];
  assign hit = rd_valid && (rd_tag == tag);

  // Invalidate only once the controller is back in IDLE, so a refill in
  // flight completes first and its line is cleared along with the rest.
  assign flush_clear = (state == IDLE) && flush_pend;

  inst_cache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAGW  (TW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush_clear),
    .idx      (idx),
    .rd_off   (off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .word_we  (word_we),
    .wr_off   (beat_q),
    .wr_word  (bus.mem_resp_data),
    .tag_we   (tag_we),
    .wr_tag   (tag)
  );

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    rvalid_c  = 1'b0;
    rdata_c   = '0;
    mreq_c    = 1'b0;
    maddr_c   = '0;
    latch     = 1'b0;
    beat_clr  = 1'b0;
    word_we   = 1'b0;
    tag_we    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = !flush_pend;
        if (bus.cpu_req && !flush_pend) begin
          latch     = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          rvalid_c = 1'b1;
          rdata_c  = rd_word;
          ready_c  = !flush_pend;
          if (bus.cpu_req && !flush_pend) begin
            latch = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mreq_c  = 1'b1;
        maddr_c = {addr_q[29:OW], {(OW + 2){1'b0}}};
        if (bus.mem_req_ready) begin
          beat_clr  = 1'b1;
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        if (bus.mem_resp_valid) begin
          word_we = 1'b1;
          if (beat_q == OW'(WORDS - 1)) begin
            tag_we    = 1'b1;
            state_nxt = RESPOND;
          end
        end
      end
      RESPOND: begin
        rvalid_c  = 1'b1;
        rdata_c   = rd_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        addr_q <= bus.cpu_addr[31:2];
      end
      if (beat_clr) begin
        beat_q <= '0;
      end else if (word_we) begin
        beat_q <= beat_q + OW'(1);
      end
      // A new pulse wins over the clearing edge so it is never lost.
      flush_pend <= bus.flush || (flush_pend && (state != IDLE));
    end
  end

  assign bus.cpu_ready     = ready_c;
  assign bus.cpu_rvalid    = rvalid_c;
  assign bus.cpu_rdata     = rdata_c;
  assign bus.mem_req_valid = mreq_c;
  assign bus.mem_req_addr  = maddr_c;

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: scenario bench for inst_cache with a scoreboard of expected
// instruction words and a burst-memory model with configurable stalls.
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_cache_if bus ();

  inst_cache #(
    .LINES (INST_CACHE_LINES),
    .WORDS (INST_CACHE_WORDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  logic [31:0] expq[$];

  int          req_stall   = 0;
  int          beat_gap    = 0;
  int unsigned mem_req_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h1C00_0010) >> 2);
  endfunction

  // Memory model: acts 2 time units after each rising edge.
  initial begin
    int          ms;
    int          stall_cnt;
    int          beat;
    int          gap_cnt;
    logic [31:0] line;
    ms = 0; stall_cnt = 0; beat = 0; gap_cnt = 0; line = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        ms = 0; stall_cnt = 0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
      end else if (ms == 0) begin
        bus.mem_resp_valid = 1'b0;
        if (bus.mem_req_valid) begin
          if (stall_cnt < req_stall) begin
            bus.mem_req_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.mem_req_ready = 1'b1;
            line = bus.mem_req_addr;
            stall_cnt = 0; beat = 0; gap_cnt = 0; ms = 1;
            mem_req_cnt++;
          end
        end else begin
          bus.mem_req_ready = 1'b0;
          stall_cnt = 0;
        end
      end else begin
        bus.mem_req_ready = 1'b0;
        if (beat == int'(INST_CACHE_WORDS)) begin
          bus.mem_resp_valid = 1'b0;
          ms = 0;
        end else if (beat == 2 && gap_cnt < beat_gap) begin
          bus.mem_resp_valid = 1'b0;
          gap_cnt++;
        end else begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_word(line + 32'(4 * beat));
          beat++;
        end
      end
    end
  end

  // Drives a request until accepted; returns at the negedge after acceptance.
  task automatic issue(input logic [31:0] a, output int unsigned acc, output bit to);
    to = 1'b1; acc = 0;
    bus.cpu_req = 1'b1; bus.cpu_addr = a;
    for (int i = 0; i < 100; i++) begin
      if (bus.cpu_ready === 1'b1) begin
        expq.push_back(mem_word({a[31:2], 2'b00}));
        acc = cyc; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int unsigned at, output bit to,
                           output logic [31:0] maddr, output bit mseen);
    to = 1'b1; d = '0; at = 0; maddr = '0; mseen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.mem_req_valid === 1'b1 && !mseen) begin
        maddr = bus.mem_req_addr; mseen = 1'b1;
      end
      if (bus.cpu_rvalid === 1'b1) begin
        d = bus.cpu_rdata; at = cyc; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors += 5;
    if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b expected 1", bus.cpu_ready); end
    if (bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b expected 0", bus.cpu_rvalid); end
    if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h expected 0", bus.cpu_rdata); end
    if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mreq got %b expected 0", bus.mem_req_valid); end
    if (bus.mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_maddr got %h expected 0", bus.mem_req_addr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    int unsigned acc, at; bit to, mseen; logic [31:0] d, maddr, exp;
    issue(32'h1C00_0010, acc, to);
    wait_resp(d, at, to, maddr, mseen);
    vectors += 3;
    if (to) begin miscompares++; $display("FAIL cold_resp timeout got none expected rvalid"); end
    else begin
      exp = expq.pop_front();
      if (d !== exp) begin miscompares++; $display("FAIL cold_data got %h expected %h", d, exp); end
      if (at - acc != 7) begin miscompares++; $display("FAIL cold_latency got %0d expected 7", at - acc); end
    end
    if (!mseen || maddr !== 32'h1C00_0010) begin
      miscompares++; $display("FAIL cold_maddr got %h (seen %b) expected 1c000010", maddr, mseen);
    end
  endtask

  task automatic test_stream_hits();
    logic [31:0] addrs [3];
    logic [31:0] exp;
    int unsigned c0;
    bit mreq;
    addrs = '{32'h1C00_0014, 32'h1C00_0018, 32'h1C00_001C};
    c0 = mem_req_cnt; mreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_req_valid !== 1'b0) mreq = 1'b1;
      if (i > 0) begin
        vectors++;
        if (bus.cpu_rvalid !== 1'b1 || expq.size() == 0) begin
          miscompares++; $display("FAIL stream_rvalid word %0d got %b expected 1", i, bus.cpu_rvalid);
        end else begin
          exp = expq.pop_front();
          if (bus.cpu_rdata !== exp) begin
            miscompares++; $display("FAIL stream_data word %0d got %h expected %h", i, bus.cpu_rdata, exp);
          end
        end
      end
      if (i < 3) begin
        vectors++;
        if (bus.cpu_ready !== 1'b1) begin
          miscompares++; $display("FAIL stream_ready word %0d got %b expected 1", i, bus.cpu_ready);
        end
        bus.cpu_req = 1'b1; bus.cpu_addr = addrs[i];
        expq.push_back(mem_word(addrs[i]));
      end else begin
        bus.cpu_req = 1'b0;
      end
      @(negedge clk);
    end
    vectors++;
    if (mreq || mem_req_cnt != c0) begin
      miscompares++; $display("FAIL stream_no_mreq got %0d requests expected 0", mem_req_cnt - c0);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3];
    int unsigned acc, at, c0; bit to, mseen; logic [31:0] d, maddr, exp;
    addrs = '{32'h1C00_0000, 32'h1C00_0100, 32'h1C00_0000};
    c0 = mem_req_cnt;
    for (int i = 0; i < 3; i++) begin
      issue(addrs[i], acc, to);
      wait_resp(d, at, to, maddr, mseen);
      vectors += 2;
      if (to) begin miscompares++; $display("FAIL conflict_resp %0d timeout expected rvalid", i); end
      else begin
        exp = expq.pop_front();
        if (d !== exp) begin miscompares++; $display("FAIL conflict_data %0d got %h expected %h", i, d, exp); end
      end
      if (mem_req_cnt != c0 + i + 1) begin
        miscompares++; $display("FAIL conflict_refill %0d got %0d refills expected %0d", i, mem_req_cnt - c0, i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned acc, at; bit to, bad, seen; logic [31:0] d, exp;
    req_stall = 5; beat_gap = 2;
    issue(32'h1C00_0020, acc, to);
    to = 1'b1; bad = 1'b0; seen = 1'b0; d = '0; at = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.mem_req_valid === 1'b1) begin
        seen = 1'b1;
        if (bus.mem_req_addr !== 32'h1C00_0020) bad = 1'b1;
      end
      if (bus.cpu_rvalid === 1'b1) begin d = bus.cpu_rdata; at = cyc; to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_stall = 0; beat_gap = 0;
    vectors += 3;
    if (!seen || bad) begin miscompares++; $display("FAIL bp_maddr_stable got seen=%b unstable=%b expected 1/0", seen, bad); end
    if (to) begin miscompares++; $display("FAIL bp_resp timeout expected rvalid"); end
    else begin
      exp = expq.pop_front();
      if (d !== exp) begin miscompares++; $display("FAIL bp_data got %h expected %h", d, exp); end
      if (at - acc != 14) begin miscompares++; $display("FAIL bp_latency got %0d expected 14", at - acc); end
    end
  endtask

  task automatic test_flush_mid_refill();
    int unsigned acc, at, c0; bit to, got, mseen; int beats; logic [31:0] d, maddr, exp;
    logic [31:0] readdr [2];
    readdr = '{32'h1C00_0030, 32'h1C00_0014};
    issue(32'h1C00_0030, acc, to);
    beats = 0; got = 1'b0; d = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.cpu_rvalid === 1'b1) begin
        got = 1'b1; d = bus.cpu_rdata;
      end else begin
        if (bus.mem_resp_valid === 1'b1) beats++;
        bus.flush = (bus.mem_resp_valid === 1'b1) && (beats == 2);
        @(negedge clk);
      end
    end
    bus.flush = 1'b0;
    vectors += 2;
    if (!got) begin miscompares++; $display("FAIL flush_resp timeout expected rvalid"); end
    else begin
      exp = expq.pop_front();
      if (d !== exp) begin miscompares++; $display("FAIL flush_data got %h expected %h", d, exp); end
    end
    if (bus.cpu_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready_respond got %b expected 0", bus.cpu_ready); end
    @(negedge clk);
    vectors++;
    if (bus.cpu_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready_pending got %b expected 0", bus.cpu_ready); end
    @(negedge clk);
    vectors++;
    if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_after got %b expected 1", bus.cpu_ready); end
    for (int i = 0; i < 2; i++) begin
      c0 = mem_req_cnt;
      issue(readdr[i], acc, to);
      wait_resp(d, at, to, maddr, mseen);
      vectors += 2;
      if (to) begin miscompares++; $display("FAIL flush_rereq_resp %0d timeout expected rvalid", i); end
      else begin
        exp = expq.pop_front();
        if (d !== exp) begin miscompares++; $display("FAIL flush_rereq_data %0d got %h expected %h", i, d, exp); end
      end
      if (mem_req_cnt != c0 + 1) begin
        miscompares++; $display("FAIL flush_rereq_miss %0d got %0d refills expected 1", i, mem_req_cnt - c0);
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    int unsigned acc, at, c0; bit to, mseen, rv_seen; int beats; logic [31:0] d, maddr, exp;
    issue(32'h1C00_0040, acc, to);
    beats = 0;
    for (int i = 0; i < 100 && beats < 2; i++) begin
      if (bus.mem_resp_valid === 1'b1) beats++;
      if (beats < 2) @(negedge clk);
    end
    vectors++;
    if (beats < 2) begin miscompares++; $display("FAIL rst_beats got %0d expected 2", beats); end
    @(negedge clk);
    reset = 1'b1;
    expq.delete();
    @(negedge clk);
    vectors += 5;
    if (bus.cpu_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b expected 1", bus.cpu_ready); end
    if (bus.cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %b expected 0", bus.cpu_rvalid); end
    if (bus.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h expected 0", bus.cpu_rdata); end
    if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mreq got %b expected 0", bus.mem_req_valid); end
    if (bus.mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_maddr got %h expected 0", bus.mem_req_addr); end
    reset = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.cpu_rvalid !== 1'b0) rv_seen = 1'b1;
    end
    vectors++;
    if (rv_seen) begin miscompares++; $display("FAIL rst_no_rvalid got 1 expected 0"); end
    c0 = mem_req_cnt;
    issue(32'h1C00_0040, acc, to);
    wait_resp(d, at, to, maddr, mseen);
    vectors += 2;
    if (to) begin miscompares++; $display("FAIL rst_rereq_resp timeout expected rvalid"); end
    else begin
      exp = expq.pop_front();
      if (d !== exp) begin miscompares++; $display("FAIL rst_rereq_data got %h expected %h", d, exp); end
    end
    if (mem_req_cnt != c0 + 1) begin
      miscompares++; $display("FAIL rst_rereq_miss got %0d refills expected 1", mem_req_cnt - c0);
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
    reset = 1'b1;
    test_reset();
    test_cold_miss();
    test_stream_hits();
    test_conflict();
    test_backpressure();
    test_flush_mid_refill();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
